cw_pipe_datapath: RTL

Parametrised, two-stage pipelined datapath driven by a decoded control word (DA/AA/BA/MB/FS/MD/RW). It generalises the fixed 16-bit, 8-register datapath to configurable width and register count. It adds a pipeline register, a WB→read forwarding path, a HOLD stall input and registered V/C/N/Z status flags. It sits between the control unit (instruction decoder) and the data memory interface.

---
 rtl/cw_dp_pkg.sv | 34 +++
 rtl/dp_regfile.sv | 43 ++++
 rtl/cw_pipe_datapath.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cw_dp_pkg.sv
// Shared definitions for the control-word pipelined datapath: function-select
// encodings, the status-flag bundle and a classifier for the add/sub codes.
package cw_dp_pkg;

  localparam logic [3:0] FS_PASSA  = 4'b0000;
  localparam logic [3:0] FS_INCA   = 4'b0001;
  localparam logic [3:0] FS_ADD    = 4'b0010;
  localparam logic [3:0] FS_ADDC   = 4'b0011;
  localparam logic [3:0] FS_ADDNB  = 4'b0100;
  localparam logic [3:0] FS_SUB    = 4'b0101;
  localparam logic [3:0] FS_DECA   = 4'b0110;
  localparam logic [3:0] FS_PASSA2 = 4'b0111;
  localparam logic [3:0] FS_AND    = 4'b1000;
  localparam logic [3:0] FS_OR     = 4'b1001;
  localparam logic [3:0] FS_XOR    = 4'b1010;
  localparam logic [3:0] FS_NOTA   = 4'b1011;
  localparam logic [3:0] FS_PASSB  = 4'b1100;
  localparam logic [3:0] FS_SHR    = 4'b1101;
  localparam logic [3:0] FS_SHL    = 4'b1110;
  localparam logic [3:0] FS_ZERO   = 4'b1111;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } status_t;

  // Codes 0001..0110 go through the adder and may produce carry/overflow.
  function automatic logic fs_is_arith(input logic [3:0] fs);
    return (fs >= FS_INCA) && (fs <= FS_DECA);
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// NREGS x WIDTH register array with two asynchronous read ports, one synchronous
// write port and bypass of the pending stage-2 writeback onto both read ports.
module dp_regfile
  import cw_dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             fwd_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    aa,
  input  logic [AW-1:0]    ba,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data
);

  logic [WIDTH-1:0] mem [NREGS];

  // NOTE: the array is cleared on reset because architectural registers must read
  // as zero afterwards; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // fwd_en ignores HOLD: a held cycle drops its control word, so the bypassed
  // value is never latched in that case.
  always_comb begin
    a_data = mem[aa];
    b_data = mem[ba];
    if (fwd_en && (wr_addr == aa)) a_data = wr_data;
    if (fwd_en && (wr_addr == ba)) b_data = wr_data;
  end

endmodule

// File: rtl/cw_pipe_datapath.sv
// Two-stage control-word datapath: stage 1 reads operands (with writeback
// bypass), stage 2 executes the function unit, writes back and updates flags.
module cw_pipe_datapath
  import cw_dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CW_VALID,
  input  logic             HOLD,
  input  logic [AW-1:0]    DA,
  input  logic [AW-1:0]    AA,
  input  logic [AW-1:0]    BA,
  input  logic             MB,
  input  logic [3:0]       FS,
  input  logic             MD,
  input  logic             RW,
  input  logic [WIDTH-1:0] CONST_IN,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] ADDR_OUT,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic [WIDTH-1:0] BUS_D,
  output logic             RESULT_VALID,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z
);

  typedef struct packed {
    logic [AW-1:0]    da;
    logic [3:0]       fs;
    logic             md;
    logic             rw;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s2_t;

  s2_t              s2_q;
  logic             s2_valid;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] op_b;
  logic             wr_pend;
  logic             wr_en;

  logic [WIDTH-1:0] x_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] f;
  status_t          flags_d;
  status_t          flags_q;

  assign wr_pend = s2_valid & s2_q.rw;
  assign wr_en   = wr_pend & ~HOLD;
  assign op_b    = MB ? CONST_IN : rd_b;

  dp_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (CLK),
    .reset   (RESET),
    .wr_en   (wr_en),
    .fwd_en  (wr_pend),
    .wr_addr (s2_q.da),
    .wr_data (BUS_D),
    .aa      (AA),
    .ba      (BA),
    .a_data  (rd_a),
    .b_data  (rd_b)
  );

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s2_q     <= '0;
      s2_valid <= 1'b0;
    end else if (!HOLD) begin
      s2_valid <= CW_VALID;
      if (CW_VALID) s2_q <= '{da: DA, fs: FS, md: MD, rw: RW, a: rd_a, b: op_b};
      else          s2_q <= '0;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    x_op = '0;
    cin  = 1'b0;
    case (s2_q.fs)
      FS_INCA:  cin = 1'b1;
      FS_ADD:   x_op = s2_q.b;
      FS_ADDC:  begin x_op = s2_q.b;  cin = 1'b1; end
      FS_ADDNB: x_op = ~s2_q.b;
      FS_SUB:   begin x_op = ~s2_q.b; cin = 1'b1; end
      FS_DECA:  x_op = '1;
      default:  ;
    endcase
  end

  assign sum = {1'b0, s2_q.a} + {1'b0, x_op} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    f = '0;
    case (s2_q.fs)
      FS_PASSA, FS_PASSA2:                   f = s2_q.a;
      FS_INCA, FS_ADD, FS_ADDC,
      FS_ADDNB, FS_SUB, FS_DECA:             f = sum[WIDTH-1:0];
      FS_AND:   f = s2_q.a & s2_q.b;
      FS_OR:    f = s2_q.a | s2_q.b;
      FS_XOR:   f = s2_q.a ^ s2_q.b;
      FS_NOTA:  f = ~s2_q.a;
      FS_PASSB: f = s2_q.b;
      FS_SHR:   f = {1'b0, s2_q.b[WIDTH-1:1]};
      FS_SHL:   f = {s2_q.b[WIDTH-2:0], 1'b0};
      default:  f = '0;
    endcase
  end

  // Overflow is carry-into-MSB xor carry-out; the MSB sum bit recovers the former.
  always_comb begin
    flags_d.c = fs_is_arith(s2_q.fs) & sum[WIDTH];
    flags_d.v = fs_is_arith(s2_q.fs) &
                (s2_q.a[WIDTH-1] ^ x_op[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH]);
    flags_d.n = f[WIDTH-1];
    flags_d.z = (f == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) flags_q <= '0;
    else if (s2_valid && !HOLD) flags_q <= flags_d;
  end

  assign BUS_D        = s2_q.md ? DATA_IN : f;
  assign ADDR_OUT     = s2_q.a;
  assign DATA_OUT     = s2_q.b;
  assign RESULT_VALID = s2_valid;
  assign V            = flags_q.v;
  assign C            = flags_q.c;
  assign N            = flags_q.n;
  assign Z            = flags_q.z;

endmodule
